// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared opcodes, FSM states and opcode legality check
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    function automatic logic op_illegal(input logic [2:0] sel);
        return !(sel inside {ALU_FWD, ALU_ADD, ALU_AND, ALU_OR});
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - combinational two-way round-robin picker
module alu_arbiter_rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] win
);

    // ptr=0 favours requester 0 on contention, ptr=1 favours requester 1
    assign win[0] = req0 & (~req1 | ~ptr);
    assign win[1] = req1 & (~req0 |  ptr);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one external ALU between two requesters with round-robin arbitration
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] data1_0,
    input  logic [DATA_WIDTH-1:0] data2_0,
    input  logic [2:0]            select_0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] data1_1,
    input  logic [DATA_WIDTH-1:0] data2_1,
    input  logic [2:0]            select_1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  valid0,
    output logic                  valid1,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] alu_data1,
    output logic [DATA_WIDTH-1:0] alu_data2,
    output logic [2:0]            alu_select,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    state_t                state;
    logic [3:0]            cnt;
    logic                  ptr;
    logic                  owner;
    logic                  illegal;
    logic [1:0]            win;
    logic [DATA_WIDTH-1:0] win_d1;
    logic [DATA_WIDTH-1:0] win_d2;
    logic [2:0]            win_sel;

    alu_arbiter_rr_arb2 u_rr (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr),
        .win  (win)
    );

    always_comb begin
        win_d1  = data1_0;
        win_d2  = data2_0;
        win_sel = select_0;
        if (win[1]) begin
            win_d1  = data1_1;
            win_d2  = data2_1;
            win_sel = select_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            illegal    <= 1'b0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            valid0     <= 1'b0;
            valid1     <= 1'b0;
            err        <= 1'b0;
            result     <= '0;
            busy       <= 1'b0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= ALU_FWD;
        end else begin
            // handshake pulses last one cycle; a new grant below may re-assert gnt
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        owner      <= win[1];
                        illegal    <= op_illegal(win_sel);
                        alu_data1  <= win_d1;
                        alu_data2  <= win_d2;
                        alu_select <= op_illegal(win_sel) ? ALU_FWD : win_sel;
                        gnt0       <= win[0];
                        gnt1       <= win[1];
                        busy       <= 1'b1;
                        cnt        <= 4'(WAIT_CYCLES - 1);
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        result <= illegal ? '0 : alu_result;
                        valid0 <= ~owner;
                        valid1 <= owner;
                        err    <= illegal;
                        busy   <= 1'b0;
                        ptr    <= ~owner;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // instance A: WAIT_CYCLES=1
    logic       req0, req1;
    logic [7:0] data1_0, data2_0, data1_1, data2_1;
    logic [2:0] select_0, select_1;
    logic       gnt0, gnt1, valid0, valid1, err, busy;
    logic [7:0] result, alu_data1, alu_data2, alu_result;
    logic [2:0] alu_select;

    // instance B: WAIT_CYCLES=3
    logic       b_req0, b_req1;
    logic [7:0] b_data1_0, b_data2_0, b_data1_1, b_data2_1;
    logic [2:0] b_select_0, b_select_1;
    logic       b_gnt0, b_gnt1, b_valid0, b_valid1, b_err, b_busy;
    logic [7:0] b_result, b_alu_data1, b_alu_data2, b_alu_result;
    logic [2:0] b_alu_select;

    alu_arbiter #(.WAIT_CYCLES(1), .DATA_WIDTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .data1_0(data1_0), .data2_0(data2_0), .select_0(select_0),
        .req1(req1), .data1_1(data1_1), .data2_1(data2_1), .select_1(select_1),
        .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1), .err(err),
        .result(result), .busy(busy), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_select(alu_select), .alu_result(alu_result)
    );

    alu_arbiter #(.WAIT_CYCLES(3), .DATA_WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .data1_0(b_data1_0), .data2_0(b_data2_0), .select_0(b_select_0),
        .req1(b_req1), .data1_1(b_data1_1), .data2_1(b_data2_1), .select_1(b_select_1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .valid0(b_valid0), .valid1(b_valid1), .err(b_err),
        .result(b_result), .busy(b_busy), .alu_data1(b_alu_data1), .alu_data2(b_alu_data2),
        .alu_select(b_alu_select), .alu_result(b_alu_result)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'b000:  return b;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result   = alu_f(alu_data1, alu_data2, alu_select);
    assign b_alu_result = alu_f(b_alu_data1, b_alu_data2, b_alu_select);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {gnt1,gnt0,valid1,valid0,err,busy}
    function automatic logic [5:0] flags_a();
        return {gnt1, gnt0, valid1, valid0, err, busy};
    endfunction

    function automatic logic [5:0] flags_b();
        return {b_gnt1, b_gnt0, b_valid1, b_valid0, b_err, b_busy};
    endfunction

    task automatic run_op(input string tag, input logic who, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [2:0] sel,
                          input logic [7:0] exp_res, input logic exp_err);
        if (who) begin
            req1 = 1'b1; data1_1 = d1; data2_1 = d2; select_1 = sel;
        end else begin
            req0 = 1'b1; data1_0 = d1; data2_0 = d2; select_0 = sel;
        end
        tick();
        check({tag, "_gnt"}, {26'd0, flags_a()}, who ? 32'b100001 : 32'b010001);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check({tag, "_valid"}, {26'd0, flags_a()}, who ? {26'd0, 3'b001, 1'b0, exp_err, 1'b0}
                                                      : {26'd0, 3'b000, 1'b1, exp_err, 1'b0});
        check({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
        tick();
        check({tag, "_idle"}, {26'd0, flags_a()}, 32'd0);
    endtask

    initial begin
        req0 = 0; req1 = 0; data1_0 = 0; data2_0 = 0; select_0 = 0;
        data1_1 = 0; data2_1 = 0; select_1 = 0;
        b_req0 = 0; b_req1 = 0; b_data1_0 = 0; b_data2_0 = 0; b_select_0 = 0;
        b_data1_1 = 0; b_data2_1 = 0; b_select_1 = 0;

        tick();
        tick();
        check("reset_a", {7'd0, flags_a(), result, alu_data1, alu_select}, 32'd0);
        check("reset_a_d2", {24'd0, alu_data2}, 32'd0);
        check("reset_b", {7'd0, flags_b(), b_result, b_alu_data1, b_alu_select}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single ADD, then operation coverage and wrap
        run_op("add", 1'b0, 8'h0F, 8'hF0, 3'b001, 8'hFF, 1'b0);
        run_op("fwd", 1'b0, 8'h0F, 8'hF0, 3'b000, 8'hF0, 1'b0);
        run_op("and", 1'b0, 8'h0F, 8'hF0, 3'b010, 8'h00, 1'b0);
        run_op("or",  1'b0, 8'h8F, 8'hB0, 3'b011, 8'hBF, 1'b0);
        run_op("wrap", 1'b0, 8'hFF, 8'h01, 3'b001, 8'h00, 1'b0);

        // illegal opcode from requester 1; ALU_SELECT forced to FORWARD
        req1 = 1'b1; data1_1 = 8'h12; data2_1 = 8'h34; select_1 = 3'b101;
        tick();
        check("ill_gnt", {26'd0, flags_a()}, 32'b100001);
        check("ill_alusel", {29'd0, alu_select}, 32'd0);
        req1 = 1'b0;
        tick();
        check("ill_valid", {26'd0, flags_a()}, 32'b001010);
        check("ill_result", {24'd0, result}, 32'd0);
        tick();

        // contention: pointer now favours 0
        req0 = 1'b1; data1_0 = 8'h01; data2_0 = 8'h02; select_0 = 3'b001;
        req1 = 1'b1; data1_1 = 8'h10; data2_1 = 8'h01; select_1 = 3'b011;
        tick();
        check("ctn_gnt0", {26'd0, flags_a()}, 32'b010001);
        req0 = 1'b0;
        tick();
        check("ctn_valid0", {26'd0, flags_a()}, 32'b000100);
        check("ctn_res0", {24'd0, result}, 32'h03);
        tick();
        check("ctn_gnt1", {26'd0, flags_a()}, 32'b100001);
        req1 = 1'b0;
        tick();
        check("ctn_valid1", {26'd0, flags_a()}, 32'b001000);
        check("ctn_res1", {24'd0, result}, 32'h11);
        tick();

        // asynchronous reset in the middle of an ADD
        req0 = 1'b1; data1_0 = 8'h22; data2_0 = 8'h33; select_0 = 3'b001;
        tick();
        check("rst_pre_gnt", {26'd0, flags_a()}, 32'b010001);
        req0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {7'd0, flags_a(), result, alu_data1, alu_select}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_no_valid", {26'd0, flags_a()}, 32'd0);
        run_op("post_rst", 1'b1, 8'h03, 8'h04, 3'b001, 8'h07, 1'b0);

        // WAIT_CYCLES=3 with a late requester 1
        b_req0 = 1'b1; b_data1_0 = 8'h05; b_data2_0 = 8'h06; b_select_0 = 3'b001;
        tick();
        check("w3_gnt0", {26'd0, flags_b()}, 32'b010001);
        check("w3_alu", {5'd0, b_alu_data1, b_alu_data2, b_alu_select, 8'd0}, {5'd0, 8'h05, 8'h06, 3'b001, 8'd0});
        b_req0 = 1'b0; b_data1_0 = 8'hAA; b_data2_0 = 8'h55; b_select_0 = 3'b011;
        b_req1 = 1'b1; b_data1_1 = 8'h00; b_data2_1 = 8'h5A; b_select_1 = 3'b000;
        tick();
        check("w3_exec1", {26'd0, flags_b()}, 32'b000001);
        check("w3_alu1", {5'd0, b_alu_data1, b_alu_data2, b_alu_select, 8'd0}, {5'd0, 8'h05, 8'h06, 3'b001, 8'd0});
        tick();
        check("w3_exec2", {26'd0, flags_b()}, 32'b000001);
        check("w3_alu2", {5'd0, b_alu_data1, b_alu_data2, b_alu_select, 8'd0}, {5'd0, 8'h05, 8'h06, 3'b001, 8'd0});
        tick();
        check("w3_valid0", {26'd0, flags_b()}, 32'b000100);
        check("w3_res0", {24'd0, b_result}, 32'h0B);
        tick();
        check("w3_gnt1", {26'd0, flags_b()}, 32'b100001);
        b_req1 = 1'b0;
        tick();
        tick();
        check("w3_busy1", {26'd0, flags_b()}, 32'b000001);
        tick();
        check("w3_valid1", {26'd0, flags_b()}, 32'b001000);
        check("w3_res1", {24'd0, b_result}, 32'h5A);
        tick();
        check("w3_idle", {26'd0, flags_b()}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
